// File: rtl/pop_delay_array_if.sv
// Pop channel bundle between an upstream buffer controller and pop_delay_array.
// The controller is the master; the delay array is the slave.
interface pop_delay_array_if #(
    parameter int unsigned NCH = 4
);
    logic           mode;
    logic [NCH-1:0] pop_in;
    logic [NCH-1:0] pop_out;
    logic           tick;
    logic [NCH-1:0] ovf;
    logic           busy;

    modport master (
        output mode,
        output pop_in,
        input  pop_out,
        input  tick,
        input  ovf,
        input  busy
    );

    modport slave (
        input  mode,
        input  pop_in,
        output pop_out,
        output tick,
        output ovf,
        output busy
    );
endinterface

// File: rtl/pop_delay_array.sv
// Per-channel pop delay line with slot-rate adaptation: either sample-and-hold once per
// slot (mode 0) or count pops and replay them one per slot without loss (mode 1).
module pop_delay_array #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned DELAY  = 2,
    parameter int unsigned PERIOD = 3,
    parameter int unsigned CNT_W  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    pop_delay_array_if.slave       bus
);
    localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] PMAX = {CNT_W{1'b1}};

    logic [NCH-1:0]   dl_q   [DELAY];
    logic [PW-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0] pend_q [NCH];
    logic [CNT_W-1:0] pend_d [NCH];
    logic [NCH-1:0]   pop_q, pop_d;
    logic [NCH-1:0]   ovf_q, ovf_d;
    logic             tick_q, tick_d;
    logic             mode_q, mode_d;

    logic [NCH-1:0]   d_out;
    logic [NCH-1:0]   dec;
    logic             slot;

    assign d_out = dl_q[DELAY-1];
    assign slot  = (phase_q == PW'(PERIOD - 1));

    always_comb begin
        dec = '0;
        for (int i = 0; i < NCH; i++) begin
            dec[i] = slot && (pend_q[i] != '0);
        end
    end

    always_comb begin
        phase_d = slot ? '0 : phase_q + PW'(1);
        tick_d  = slot;
        pop_d   = pop_q;
        ovf_d   = ovf_q;
        pend_d  = pend_q;
        mode_d  = mode_q;
        if (bus.mode != mode_q) begin
            // Mode switch restarts the slot grid and drops anything pending.
            mode_d  = bus.mode;
            phase_d = '0;
            tick_d  = 1'b0;
            pop_d   = '0;
            for (int i = 0; i < NCH; i++) pend_d[i] = '0;
        end else if (!mode_q) begin
            if (slot) pop_d = d_out;
            for (int i = 0; i < NCH; i++) pend_d[i] = '0;
        end else begin
            pop_d = dec;
            for (int i = 0; i < NCH; i++) begin
                if (d_out[i] && !dec[i] && (pend_q[i] == PMAX)) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + CNT_W'(d_out[i]) - CNT_W'(dec[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_q    <= '{default: '0};
            phase_q <= '0;
            pend_q  <= '{default: '0};
            pop_q   <= '0;
            ovf_q   <= '0;
            tick_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            dl_q[0] <= bus.pop_in;
            for (int k = 1; k < DELAY; k++) dl_q[k] <= dl_q[k-1];
            phase_q <= phase_d;
            pend_q  <= pend_d;
            pop_q   <= pop_d;
            ovf_q   <= ovf_d;
            tick_q  <= tick_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (pend_q[i] != '0) bus.busy = 1'b1;
        end
    end

    assign bus.pop_out = pop_q;
    assign bus.ovf     = ovf_q;
    assign bus.tick    = tick_q;
endmodule

// File: doc/pop_delay_array.md
POP_DELAY_ARRAY -- requirements
Module: pop_delay_array

Interface
REQ-001 Parameter NCH, default 4: number of independent pop channels.
REQ-002 Parameter DELAY, default 2: pipeline delay stages per channel, legal range >= 1.
REQ-003 Parameter PERIOD, default 3: sample-slot period in clock cycles, legal range >= 2.
REQ-004 Parameter CNT_W, default 3: width of the per-channel pending counter; PMAX = 2^CNT_W-1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mode  input  1  0 = sampled (level hold), 1 = counted (lossless pulses).
REQ-008 pop_in  input  NCH  per-channel pop request from upstream buffer.
REQ-009 pop_out  output  NCH  registered, delayed/rate-adapted pop to virtual channel.
REQ-010 tick  output  1  registered; high for the one cycle following each slot edge.
REQ-011 ovf  output  NCH  registered, sticky pending-counter overflow per channel.
REQ-012 busy  output  1  high when any channel pending counter is nonzero; decoded from registers only.

Function
REQ-013 Each channel SHALL carry pop_in through a DELAY-stage shift register; d_out[i] = last stage value before the edge.
REQ-014 Phase counter SHALL count 0..PERIOD-1, +1 per cycle, wrapping to 0; a "slot edge" is an edge where phase == PERIOD-1 before the edge.
REQ-015 tick SHALL be 1 after a slot edge, 0 after every other edge.
REQ-016 Mode 0: on slot edge pop_out[i] <= d_out[i]; on all other edges pop_out holds; pending counters SHALL stay 0.
REQ-017 Mode 1: per edge, inc = d_out[i]; dec = slot edge AND pend[i] != 0 (pre-edge value); pop_out[i] <= dec.
REQ-018 Mode 1: pend[i] <= pend[i] + inc - dec; inc and dec together leave pend unchanged.
REQ-019 Mode 1: inc with pend == PMAX and no dec SHALL leave pend at PMAX, drop the pop, and set ovf[i].
REQ-020 Mode 1 pop_out SHALL be a single-cycle pulse; at most one pulse per channel per PERIOD cycles.
REQ-021 A pop arriving on a slot edge (inc with pend == 0) SHALL be emitted no earlier than the next slot edge.
REQ-022 mode SHALL be registered internally (mode_r); on an edge where mode != mode_r: all pend cleared, pop_out cleared, tick cleared, phase <= 0, mode_r <= mode; delay line and ovf unaffected; no inc/dec applied that edge.
REQ-023 ovf[i] SHALL clear only by reset.
REQ-024 Channels SHALL be fully independent; activity on one SHALL not alter another's pend, pop_out or ovf.

Reset
REQ-025 While reset is high at an edge: delay line, phase, pend, pop_out, tick, ovf, mode_r <= 0 (mode_r resets to 0, so mode sampled as 1 after release triggers REQ-022 on the first edge); busy = 0.
REQ-026 Reset SHALL take priority over all other activity, including mid-burst and mid-slot; pending pops are discarded.
REQ-027 After release the first slot edge SHALL be the PERIOD-th edge (mode held at 0).

Verification (NCH=4, DELAY=2, PERIOD=3, CNT_W=3)
REQ-028 reset high 2 cycles with pop_in=4'hF, mode=0 -> pop_out=0, ovf=0, busy=0; after release tick first 1 after 3rd edge.
REQ-029 Mode 0, pop_in[0]=1 for the one cycle with phase=0 -> pop_out[0]=1 after edge 3, held 3 cycles, 0 after edge 6.
REQ-030 Mode 1, pop_in[1]=1 for 4 consecutive cycles -> exactly 4 single-cycle pulses on pop_out[1], 3 cycles apart, each coincident with tick; busy 0 after last pulse; ovf=0.
REQ-031 Mode 1, pop_in[2] held 1 for 12 cycles -> pend[2] never exceeds 7, ovf[2]=1 and stays 1 until reset, fewer than 12 pulses emitted, busy returns 0.
REQ-032 Mode 1, pend[3]=1 and d_out[3]=1 on a slot edge -> pop_out[3] pulses, pend[3] remains 1, next slot edge pulses again.
REQ-033 Mode 1 with pend[0]=3, then mode set to 0 -> next edge: pend=0, busy=0, pop_out=0, phase=0; no further pulses; next tick after 3 edges.
